// File: rtl/phase_pkg.sv
// Shared types and constants for the phase tag statistics block.
package phase_pkg;

  localparam int PHASE_STATS_W = 28;
  localparam int DROP_CNT_W    = 16;

  typedef struct packed {
    logic [PHASE_STATS_W-1:0] mean;
    logic [PHASE_STATS_W-1:0] min;
    logic [PHASE_STATS_W-1:0] max;
  } phase_stats_t;

endpackage

// File: rtl/phase_tag_window_acc.sv
// Window accumulator: running sum, tag counter and (optionally) min/max.
// Min/max tracking is built only when PHASE_TAG_STATS_MINMAX_EN is defined.
module phase_tag_window_acc
  import phase_pkg::*;
#(
  parameter int PHASE_COUNT_SIZE = PHASE_STATS_W,
  parameter int LOG2_WINDOW      = 4
) (
  input  logic                        clk_sample,
  input  logic                        rst,
  input  logic [PHASE_COUNT_SIZE-1:0] tag_i,
  input  logic                        tag_valid_i,
  output logic                        done_o,
  output logic [PHASE_COUNT_SIZE-1:0] mean_o,
  output logic [PHASE_COUNT_SIZE-1:0] min_o,
  output logic [PHASE_COUNT_SIZE-1:0] max_o
);

  localparam int SUM_W = PHASE_COUNT_SIZE + LOG2_WINDOW;

  logic [SUM_W-1:0]       sum_q, sum_d, sum_inc;
  logic [LOG2_WINDOW-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum_inc = sum_q + {{LOG2_WINDOW{1'b0}}, tag_i};
    done_o  = tag_valid_i && (cnt_q == {LOG2_WINDOW{1'b1}});
    mean_o  = sum_inc[SUM_W-1:LOG2_WINDOW];
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    if (tag_valid_i) begin
      cnt_d = cnt_q + LOG2_WINDOW'(1);
      sum_d = done_o ? '0 : sum_inc;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_sample) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef PHASE_TAG_STATS_MINMAX_EN
  logic [PHASE_COUNT_SIZE-1:0] min_q, min_d, max_q, max_d;

  // min_o/max_o already include the current tag, which is what the Nth tag needs.
  always_comb begin
    min_o = (tag_i < min_q) ? tag_i : min_q;
    max_o = (tag_i > max_q) ? tag_i : max_q;
    min_d = min_q;
    max_d = max_q;
    if (tag_valid_i) begin
      min_d = done_o ? '1 : min_o;
      max_d = done_o ? '0 : max_o;
    end
  end

  always_ff @(posedge clk_sample) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end
`else
  assign min_o = '0;
  assign max_o = '0;
`endif

endmodule

// File: rtl/phase_tag_stats.sv
// Windowed phase tag statistics with a valid/ready record output and drop counter.
// Optional min/max tracking: define PHASE_TAG_STATS_MINMAX_EN.
module phase_tag_stats
  import phase_pkg::*;
#(
  parameter int PHASE_COUNT_SIZE = PHASE_STATS_W,
  parameter int LOG2_WINDOW      = 4
) (
  input  logic                        clk_sample,
  input  logic                        rst,
  input  logic [PHASE_COUNT_SIZE-1:0] phase_tag,
  input  logic                        phase_tag_valid,
  output logic                        stat_valid,
  input  logic                        stat_ready,
  output logic [PHASE_COUNT_SIZE-1:0] stat_mean,
  output logic [PHASE_COUNT_SIZE-1:0] stat_min,
  output logic [PHASE_COUNT_SIZE-1:0] stat_max,
  output logic [DROP_CNT_W-1:0]       stat_dropped
);

  logic                        win_done;
  logic [PHASE_COUNT_SIZE-1:0] win_mean, win_min, win_max;
  phase_stats_t                win_rec, rec_q, rec_d;
  logic                        valid_q, valid_d, accept;
  logic [DROP_CNT_W-1:0]       dropped_q, dropped_d;

  phase_tag_window_acc #(
    .PHASE_COUNT_SIZE (PHASE_COUNT_SIZE),
    .LOG2_WINDOW      (LOG2_WINDOW)
  ) u_acc (
    .clk_sample  (clk_sample),
    .rst         (rst),
    .tag_i       (phase_tag),
    .tag_valid_i (phase_tag_valid),
    .done_o      (win_done),
    .mean_o      (win_mean),
    .min_o       (win_min),
    .max_o       (win_max)
  );

  assign win_rec = '{mean: win_mean, min: win_min, max: win_max};
  assign accept  = valid_q && stat_ready;

  // A completed window loads only into an empty or just-accepted slot; otherwise it is lost.
  always_comb begin
    valid_d   = valid_q;
    rec_d     = rec_q;
    dropped_d = dropped_q;
    if (win_done) begin
      if (!valid_q || accept) begin
        rec_d   = win_rec;
        valid_d = 1'b1;
      end else if (dropped_q != {DROP_CNT_W{1'b1}}) begin
        dropped_d = dropped_q + DROP_CNT_W'(1);
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sample) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rec_q     <= '0;
      dropped_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rec_q     <= rec_d;
      dropped_q <= dropped_d;
    end
  end

  assign stat_valid   = valid_q;
  assign stat_mean    = rec_q.mean;
  assign stat_min     = rec_q.min;
  assign stat_max     = rec_q.max;
  assign stat_dropped = dropped_q;

endmodule

// File: tb/tb_phase_tag_stats.sv
// Self-checking bench for phase_tag_stats (PHASE_COUNT_SIZE=28, LOG2_WINDOW=2).
module tb_phase_tag_stats;

  localparam int W = 28;
  localparam int L = 2;
  localparam int N = 4;
`ifdef PHASE_TAG_STATS_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] mean;
    logic [W-1:0] min;
    logic [W-1:0] max;
  } rec_t;

  logic          clk_sample = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  phase_tag = '0;
  logic          phase_tag_valid = 1'b0;
  logic          stat_valid;
  logic          stat_ready = 1'b0;
  logic [W-1:0]  stat_mean, stat_min, stat_max;
  logic [15:0]   stat_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  rec_t         q[$];
  bit           m_valid = 1'b0;
  int unsigned  m_dropped = 0;
  longint       w_sum = 0;
  int           w_cnt = 0;
  logic [W-1:0] w_min = '1;
  logic [W-1:0] w_max = '0;

  phase_tag_stats #(.PHASE_COUNT_SIZE(W), .LOG2_WINDOW(L)) dut (
    .clk_sample      (clk_sample),
    .rst             (rst),
    .phase_tag       (phase_tag),
    .phase_tag_valid (phase_tag_valid),
    .stat_valid      (stat_valid),
    .stat_ready      (stat_ready),
    .stat_mean       (stat_mean),
    .stat_min        (stat_min),
    .stat_max        (stat_max),
    .stat_dropped    (stat_dropped)
  );

  always #5 clk_sample = ~clk_sample;

  // One clock: scoreboard compare at negedge, model the coming edge, return at posedge+1.
  task automatic cycle();
    bit   acc, done;
    rec_t r;
    @(negedge clk_sample);
    n_checks++;
    if (stat_valid !== m_valid) begin
      n_fail++;
      $display("FAIL sb_valid t=%0t got=%0b exp=%0b", $time, stat_valid, m_valid);
    end
    n_checks++;
    if (stat_dropped !== 16'(m_dropped)) begin
      n_fail++;
      $display("FAIL sb_dropped t=%0t got=%0d exp=%0d", $time, stat_dropped, m_dropped);
    end
    if (m_valid && q.size() > 0) begin
      n_checks++;
      if ({stat_mean, stat_min, stat_max} !== {q[0].mean, q[0].min, q[0].max}) begin
        n_fail++;
        $display("FAIL sb_record t=%0t got=%0h/%0h/%0h exp=%0h/%0h/%0h", $time,
                 stat_mean, stat_min, stat_max, q[0].mean, q[0].min, q[0].max);
      end
    end
    if (rst) begin
      m_valid = 1'b0; m_dropped = 0; q.delete();
      w_sum = 0; w_cnt = 0; w_min = '1; w_max = '0;
    end else begin
      acc  = m_valid && stat_ready;
      done = 1'b0;
      if (phase_tag_valid) begin
        w_sum += longint'(phase_tag);
        if (phase_tag < w_min) w_min = phase_tag;
        if (phase_tag > w_max) w_max = phase_tag;
        w_cnt++;
        done = (w_cnt == N);
      end
      if (done) begin
        r.mean = W'(w_sum / N);
        r.min  = MINMAX ? w_min : '0;
        r.max  = MINMAX ? w_max : '0;
        w_sum = 0; w_cnt = 0; w_min = '1; w_max = '0;
        if (!m_valid || acc) begin
          if (acc) void'(q.pop_front());
          q.push_back(r);
          m_valid = 1'b1;
        end else if (m_dropped != 32'hFFFF) begin
          m_dropped++;
        end
      end else if (acc) begin
        void'(q.pop_front());
        m_valid = 1'b0;
      end
    end
    @(posedge clk_sample);
    #1;
  endtask

  task automatic send(input logic [W-1:0] t);
    phase_tag = t;
    phase_tag_valid = 1'b1;
    cycle();
    phase_tag_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    stat_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() > 0 || m_valid); i++) cycle();
    n_checks++;
    if (q.size() != 0 || stat_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout got=%0d/%0b exp=0/0", q.size(), stat_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    phase_tag = 28'd5;
    phase_tag_valid = 1'b1;
    idle(3);
    n_checks++;
    if ({stat_valid, stat_mean, stat_min, stat_max, stat_dropped} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%0b/%0h/%0h/%0h/%0h exp=0", stat_valid,
               stat_mean, stat_min, stat_max, stat_dropped);
    end
    phase_tag_valid = 1'b0;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    stat_ready = 1'b1;
    send(28'd10); send(28'd20); send(28'd30);
    n_checks++;
    if (stat_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid got=%0b exp=0", stat_valid);
    end
    send(28'd40);
    n_checks++;
    if ({stat_valid, stat_mean, stat_min, stat_max} !==
        {1'b1, 28'd25, MINMAX ? 28'd10 : 28'd0, MINMAX ? 28'd40 : 28'd0}) begin
      n_fail++;
      $display("FAIL basic_record got=%0b/%0d/%0d/%0d exp=1/25/%0d/%0d", stat_valid,
               stat_mean, stat_min, stat_max, MINMAX ? 10 : 0, MINMAX ? 40 : 0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    stat_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(W'(i));
    idle(3);
    n_checks++;
    if ({stat_valid, stat_mean, stat_min, stat_max, stat_dropped} !==
        {1'b1, 28'd2, MINMAX ? 28'd1 : 28'd0, MINMAX ? 28'd4 : 28'd0, 16'd1}) begin
      n_fail++;
      $display("FAIL backpressure_hold got=%0b/%0d/%0d/%0d/%0d exp=1/2/%0d/%0d/1", stat_valid,
               stat_mean, stat_min, stat_max, stat_dropped, MINMAX ? 1 : 0, MINMAX ? 4 : 0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] drop_before;
    stat_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(28'd5);
    send(28'd6); send(28'd6); send(28'd6);
    drop_before = stat_dropped;
    stat_ready = 1'b1;
    send(28'd10);
    stat_ready = 1'b0;
    n_checks++;
    if ({stat_valid, stat_mean, stat_min, stat_max, stat_dropped} !==
        {1'b1, 28'd7, MINMAX ? 28'd6 : 28'd0, MINMAX ? 28'd10 : 28'd0, drop_before}) begin
      n_fail++;
      $display("FAIL b2b_reload got=%0b/%0d/%0d/%0d/%0d exp=1/7/%0d/%0d/%0d", stat_valid,
               stat_mean, stat_min, stat_max, stat_dropped, MINMAX ? 6 : 0, MINMAX ? 10 : 0,
               drop_before);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    stat_ready = 1'b1;
    send(28'd100); send(28'd200);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(28'd4); send(28'd4); send(28'd8); send(28'd8);
    n_checks++;
    if ({stat_valid, stat_mean, stat_min, stat_max} !==
        {1'b1, 28'd6, MINMAX ? 28'd4 : 28'd0, MINMAX ? 28'd8 : 28'd0}) begin
      n_fail++;
      $display("FAIL midreset_record got=%0b/%0d/%0d/%0d exp=1/6/%0d/%0d", stat_valid,
               stat_mean, stat_min, stat_max, MINMAX ? 4 : 0, MINMAX ? 8 : 0);
    end
    drain();
  endtask

  task automatic test_extremes();
    stat_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(28'hFFFFFFF);
    n_checks++;
    if (stat_mean !== 28'hFFFFFFF) begin
      n_fail++;
      $display("FAIL max_tags_mean got=%0h exp=fffffff", stat_mean);
    end
    send(28'd1); send(28'd2); send(28'd2); send(28'd2);
    n_checks++;
    if ({stat_mean, stat_min, stat_max} !==
        {28'd1, MINMAX ? 28'd1 : 28'd0, MINMAX ? 28'd2 : 28'd0}) begin
      n_fail++;
      $display("FAIL trunc_mean got=%0d/%0d/%0d exp=1/%0d/%0d", stat_mean, stat_min,
               stat_max, MINMAX ? 1 : 0, MINMAX ? 2 : 0);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      phase_tag       = W'($urandom);
      phase_tag_valid = ($urandom_range(0, 3) != 0);
      stat_ready      = ($urandom_range(0, 2) == 0);
      cycle();
    end
    phase_tag_valid = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_extremes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
